// File: rtl/serial_word_receiver_pkg.sv
// Shared constants for the serial link: state encoding and default word geometry.
package serial_word_receiver_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CNT_W = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/serial_word_receiver_word_hold_reg.sv
// Valid/ready holding register for completed words; flags a dropped word as overrun.
module serial_word_receiver_word_hold_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [WIDTH-1:0] word_in,
    input  logic             ready,
    input  logic             clear_flags,
    output logic [WIDTH-1:0] word_out,
    output logic             valid,
    output logic             overrun
);

    logic accept;
    logic drop;

    assign accept = load && (!valid || ready);
    assign drop   = load && valid && !ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            word_out <= '0;
            valid    <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (accept) begin
                word_out <= word_in;
                valid    <= 1'b1;
            end else if (valid && ready) begin
                valid    <= 1'b0;
            end

            // a drop in the same cycle as a clear keeps the flag set
            if (drop) begin
                overrun <= 1'b1;
            end else if (clear_flags) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/serial_word_receiver.sv
// MSB-first serial-to-parallel receiver with framing, abort detection and a word holding register.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | waiting for frame_start; bit_en ignored
// ST_SHIFT | frame in progress; each bit_en shifts one bit
module serial_word_receiver
    import serial_word_receiver_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             frame_start,
    input  logic             bit_en,
    input  logic             serial_in,
    input  logic             word_ready,
    input  logic             clear_flags,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    output logic             busy,
    output logic             overrun,
    output logic             frame_err
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] shift_reg, shift_nxt;
    logic             done;
    logic             abort;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            shift_reg <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            shift_reg <= shift_nxt;
            if (abort) begin
                frame_err <= 1'b1;
            end else if (clear_flags) begin
                frame_err <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shift_nxt = shift_reg;
        done      = 1'b0;
        abort     = 1'b0;

        if (frame_start) begin
            // a new frame always restarts; in SHIFT the partial word is thrown away
            abort     = (state == ST_SHIFT);
            state_nxt = ST_SHIFT;
            if (bit_en) begin
                shift_nxt = {{(WIDTH-1){1'b0}}, serial_in};
                cnt_nxt   = CNT_W'(1);
            end else begin
                shift_nxt = '0;
                cnt_nxt   = '0;
            end
        end else if (state == ST_SHIFT && bit_en) begin
            shift_nxt = {shift_reg[WIDTH-2:0], serial_in};
            if (cnt == CNT_W'(WIDTH-1)) begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt   = cnt + CNT_W'(1);
            end
        end
    end

    assign busy = (state == ST_SHIFT);

    serial_word_receiver_word_hold_reg #(
        .WIDTH(WIDTH)
    ) u_word_hold_reg (
        .clk        (clk),
        .resetn     (resetn),
        .load       (done),
        .word_in    (shift_nxt),
        .ready      (word_ready),
        .clear_flags(clear_flags),
        .word_out   (word_out),
        .valid      (word_valid),
        .overrun    (overrun)
    );

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed bench for serial_word_receiver: framing, gaps, overrun, abort and async reset.
module tb_serial_word_receiver;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        frame_start = 1'b0;
    logic        bit_en = 1'b0;
    logic        serial_in = 1'b0;
    logic        word_ready = 1'b0;
    logic        clear_flags = 1'b0;
    logic [15:0] word_out;
    logic        word_valid;
    logic        busy;
    logic        overrun;
    logic        frame_err;

    int errors = 0;
    int checks = 0;

    serial_word_receiver #(.WIDTH(16), .CNT_W(4)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .frame_start(frame_start),
        .bit_en     (bit_en),
        .serial_in  (serial_in),
        .word_ready (word_ready),
        .clear_flags(clear_flags),
        .word_out   (word_out),
        .word_valid (word_valid),
        .busy       (busy),
        .overrun    (overrun),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Sends bits hi..lo of w, one per bit_en; gap idle cycles follow each bit.
    task automatic send_bits(input logic [15:0] w, input int hi, input int lo,
                             input bit start, input int gap);
        for (int i = hi; i >= lo; i--) begin
            frame_start = start && (i == hi);
            bit_en      = 1'b1;
            serial_in   = w[i];
            @(negedge clk);
            frame_start = 1'b0;
            bit_en      = 1'b0;
            for (int g = 0; g < gap; g++) @(negedge clk);
        end
    endtask

    initial begin
        #12;
        chk("rst_word", word_out, 16'h0000);
        chk("rst_valid", {15'b0, word_valid}, 16'd0);
        chk("rst_busy", {15'b0, busy}, 16'd0);
        chk("rst_flags", {14'b0, overrun, frame_err}, 16'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // bit_en alone in IDLE must not start a frame
        bit_en = 1'b1; serial_in = 1'b1;
        @(negedge clk); @(negedge clk);
        bit_en = 1'b0;
        chk("idle_bit_en_busy", {15'b0, busy}, 16'd0);

        // basic word, ready low
        send_bits(16'hA5C3, 15, 1, 1, 0);
        chk("basic_busy_mid", {15'b0, busy}, 16'd1);
        chk("basic_valid_early", {15'b0, word_valid}, 16'd0);
        send_bits(16'hA5C3, 0, 0, 0, 0);
        chk("basic_valid", {15'b0, word_valid}, 16'd1);
        chk("basic_word", word_out, 16'hA5C3);
        chk("basic_busy", {15'b0, busy}, 16'd0);
        chk("basic_flags", {14'b0, overrun, frame_err}, 16'd0);
        word_ready = 1'b1;
        @(negedge clk);
        chk("accept_valid", {15'b0, word_valid}, 16'd0);
        chk("accept_word_kept", word_out, 16'hA5C3);

        // gapped strobes, ready held high
        send_bits(16'hA5C3, 15, 1, 1, 2);
        chk("gap_valid_early", {15'b0, word_valid}, 16'd0);
        send_bits(16'hA5C3, 0, 0, 0, 0);
        chk("gap_valid", {15'b0, word_valid}, 16'd1);
        chk("gap_word", word_out, 16'hA5C3);
        @(negedge clk);
        chk("gap_valid_pulse", {15'b0, word_valid}, 16'd0);

        // overrun
        word_ready = 1'b0;
        send_bits(16'h1234, 15, 0, 1, 0);
        chk("ovr_first_word", word_out, 16'h1234);
        chk("ovr_no_flag_yet", {15'b0, overrun}, 16'd0);
        send_bits(16'hFFFF, 15, 0, 1, 0);
        chk("ovr_word_kept", word_out, 16'h1234);
        chk("ovr_flag", {15'b0, overrun}, 16'd1);
        chk("ovr_valid", {15'b0, word_valid}, 16'd1);
        word_ready = 1'b1;
        @(negedge clk);
        word_ready = 1'b0;
        chk("ovr_drain_valid", {15'b0, word_valid}, 16'd0);
        chk("ovr_sticky", {15'b0, overrun}, 16'd1);
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        chk("ovr_cleared", {15'b0, overrun}, 16'd0);

        // back-to-back, ready only on the completion cycle
        send_bits(16'h5A5A, 15, 0, 1, 0);
        chk("b2b_first", word_out, 16'h5A5A);
        send_bits(16'h00FF, 15, 1, 1, 0);
        word_ready = 1'b1;
        send_bits(16'h00FF, 0, 0, 0, 0);
        word_ready = 1'b0;
        chk("b2b_word", word_out, 16'h00FF);
        chk("b2b_valid", {15'b0, word_valid}, 16'd1);
        chk("b2b_no_ovr", {15'b0, overrun}, 16'd0);
        @(negedge clk);
        chk("b2b_valid_held", {15'b0, word_valid}, 16'd1);
        word_ready = 1'b1;
        @(negedge clk);
        word_ready = 1'b0;
        chk("b2b_drained", {15'b0, word_valid}, 16'd0);

        // abort after 7 bits of 0xDEAD, then full 0xBEEF
        send_bits(16'hDEAD, 15, 9, 1, 0);
        chk("abort_no_err_yet", {15'b0, frame_err}, 16'd0);
        send_bits(16'hBEEF, 15, 15, 1, 0);
        chk("abort_err", {15'b0, frame_err}, 16'd1);
        chk("abort_busy", {15'b0, busy}, 16'd1);
        chk("abort_no_word", {15'b0, word_valid}, 16'd0);
        send_bits(16'hBEEF, 14, 1, 0, 0);
        chk("abort_valid_early", {15'b0, word_valid}, 16'd0);
        send_bits(16'hBEEF, 0, 0, 0, 0);
        chk("abort_word", word_out, 16'hBEEF);
        chk("abort_valid", {15'b0, word_valid}, 16'd1);

        // set beats clear when both land in the same cycle
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        chk("err_cleared", {15'b0, frame_err}, 16'd0);
        send_bits(16'h0000, 15, 13, 1, 0);
        clear_flags = 1'b1;
        send_bits(16'h0000, 15, 15, 1, 0);
        clear_flags = 1'b0;
        chk("err_set_wins", {15'b0, frame_err}, 16'd1);

        // async reset between edges, mid-frame
        send_bits(16'h8001, 15, 7, 1, 0);
        chk("rst_pre_busy", {15'b0, busy}, 16'd1);
        #2 resetn = 1'b0;
        #1;
        chk("arst_word", word_out, 16'h0000);
        chk("arst_valid", {15'b0, word_valid}, 16'd0);
        chk("arst_busy", {15'b0, busy}, 16'd0);
        chk("arst_flags", {14'b0, overrun, frame_err}, 16'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        send_bits(16'h8001, 15, 0, 1, 0);
        chk("post_rst_word", word_out, 16'h8001);
        chk("post_rst_valid", {15'b0, word_valid}, 16'd1);
        chk("post_rst_flags", {14'b0, overrun, frame_err}, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_word_receiver.md
Name: serial_word_receiver

Overview:
- Receive end of the team's parallel-load/serial-shift link. Deserializes an MSB-first serial stream into WIDTH-bit words.
- Sits downstream of the shift-register transmitter. Presents each completed word to the consumer through a valid/ready holding register.
- Detects overrun and aborted frames with sticky flags.

Parameters:
- WIDTH, 16, bits per word; also the serial frame length.
- CNT_W, 4, bit-counter width; must satisfy 2**CNT_W >= WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- frame_start  input  1  one-cycle pulse marking the first bit of a frame.
- bit_en  input  1  sample strobe; serial_in is valid on cycles where this is high.
- serial_in  input  1  serial data, MSB first.
- word_ready  input  1  consumer accepts word_out when high together with word_valid.
- clear_flags  input  1  synchronous clear of the sticky flags.
- word_out  output  WIDTH  last completed word, held stable while word_valid is high.
- word_valid  output  1  word_out holds an unconsumed word.
- busy  output  1  frame in progress (state SHIFT).
- overrun  output  1  sticky: a completed word was dropped because the holding register was full.
- frame_err  output  1  sticky: frame_start arrived during SHIFT and aborted a partial frame.

Behaviour:
- Reset (resetn low, asynchronous):
  - state=IDLE, bit count=0, shift register=0.
  - word_out=0, word_valid=0, busy=0, overrun=0, frame_err=0.
- State IDLE:
  - frame_start=1 moves to SHIFT and clears the count.
  - If bit_en is also 1 in that cycle, serial_in is captured as the first bit and the count becomes 1.
  - bit_en without frame_start is ignored.
- State SHIFT:
  - On each bit_en: shift_reg <= {shift_reg[WIDTH-2:0], serial_in}; count increments.
  - First received bit ends in bit WIDTH-1.
- Word completion:
  - Completion is the cycle the WIDTH-th bit is sampled.
  - The assembled word, including that bit, is offered to the holding register in the same edge.
  - State returns to IDLE and the count resets to 0.
- Holding register, evaluated on the completion edge:
  - word_valid=0: load word_out; word_valid<=1.
  - word_valid=1 and word_ready=1: load the new word; word_valid stays 1; no overrun.
  - word_valid=1 and word_ready=0: new word discarded; word_out unchanged; overrun<=1.
  - Without completion: word_valid && word_ready clears word_valid; word_out keeps its value.
- Latency: word_valid rises the cycle after the edge that samples the last bit, one clk after the final bit_en.
- frame_start while in SHIFT:
  - Partial frame discarded; frame_err<=1; count restarts at 0.
  - That cycle's bit_en is taken as bit 1 of the new frame, as in IDLE.
- Gaps: bit_en may have arbitrary gaps inside a frame; no timeout.
- busy = (state==SHIFT).
- Sticky flags:
  - clear_flags=1 clears overrun and frame_err.
  - A new set event in the same cycle wins; the flag stays 1.
- Reset mid-frame: immediately returns everything to reset values; the partial word is lost.

Decomposition:
- Shared package:
  - state encoding constants: ST_IDLE=1'b0, ST_SHIFT=1'b1.
  - default WIDTH/CNT_W constants shared with the transmitter.
- One natural sub-module: word_hold_reg, the valid/ready holding register with overrun detection.
- The shifter, counter and FSM stay in the top module.

Test Plan:
- Basic word: after reset, frame_start+bit_en with serial bits 0xA5C3 MSB first, bit_en every cycle -> word_valid=1 one cycle after the 16th bit; word_out=16'hA5C3; busy=0; flags=0.
- Gapped strobes: same frame with bit_en every 3rd cycle, word_ready held 1 -> word_out=16'hA5C3; word_valid pulses for 1 cycle.
- Overrun: word_ready=0; send 0x1234 then 0xFFFF -> word_out stays 16'h1234; overrun=1. Then word_ready=1 -> word_valid=0. Then clear_flags -> overrun=0.
- Back-to-back with acceptance: word_ready=1 on the completion cycle of a second word 0x00FF -> word_out=16'h00FF; word_valid stays 1; overrun=0.
- Abort: frame_start after 7 bits of 0xDEAD, then full frame 0xBEEF -> frame_err=1; word_out=16'hBEEF; no word produced for the partial frame.
- Async reset mid-frame: resetn low after 9 bits, asserted between clock edges -> all outputs 0 immediately. After release, a full frame 0x8001 -> word_out=16'h8001.
